// File: rtl/psram_frame_writer.sv
`timescale 1ns/1ps
// Packs an 8-bit pixel stream into 16-bit words and writes them into the PSRAM frame buffer
// with asynchronous write cycles. Optional macro PSRAM_WR_TESTPAT_EN adds a test-pattern source (test_en).
module psram_frame_writer #(
    parameter int WORDS_PER_LINE = 320,
    parameter int LINES          = 480,
    parameter int LINE_STRIDE    = 640,
    parameter int WR_PULSE       = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef PSRAM_WR_TESTPAT_EN
    input  logic        test_en,
`endif
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    input  logic        pix_sof,
    output logic        pix_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [22:0] MemAdr,
    output logic [15:0] MemDataOut,
    output logic        MemDataOE,
    output logic        MemOE,
    output logic        MemWR,
    output logic        RamCE,
    output logic        RamLB,
    output logic        RamUB,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_WRITE   = 3'd2,
        S_HOLD    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_wcnt, w_wcnt_nxt;
    logic [15:0] r_line, w_line_nxt, r_col, w_col_nxt;
    logic [7:0]  r_lo, w_lo_nxt;
    logic        r_lo_full, w_lo_full_nxt, r_lo_sof, w_lo_sof_nxt;
    logic [15:0] r_pend, w_pend_nxt;
    logic        r_pend_full, w_pend_full_nxt, r_pend_sof, w_pend_sof_nxt;
    logic [22:0] r_mem_adr, w_adr_nxt;
    logic [15:0] r_mem_data, w_data_nxt;
    logic        r_mem_data_oe, w_oe_nxt;
    logic        r_mem_oe;
    logic        r_mem_wr, w_wr_nxt;
    logic        r_ram_ce, w_ce_nxt;
    logic        r_ram_be, w_be_nxt;
    logic        r_bus_req, w_req_nxt;
    logic        r_frame_done, w_done_nxt;
    logic        r_pix_ready, w_ready_nxt;

    logic        w_test;
    logic [15:0] w_pat;
    logic        w_launch;
    logic        w_accept;
    logic        w_src_full;
    logic [15:0] w_src_word;
    logic        w_src_sof;
    logic [15:0] w_line_use, w_col_use;
    logic [22:0] w_adr;

`ifdef PSRAM_WR_TESTPAT_EN
    assign w_test = test_en;
    assign w_pat  = {r_col[6:0], 1'b1, r_col[6:0], 1'b0} ^ {2{r_line[7:0]}};
`else
    assign w_test = 1'b0;
    assign w_pat  = 16'h0000;
`endif

    // The word source is the packer's pending slot, or the pattern generator in test mode
    assign w_src_full = w_test | r_pend_full;
    assign w_src_word = w_test ? w_pat : r_pend;
    assign w_src_sof  = ~w_test & r_pend_sof;
    assign w_line_use = w_src_sof ? 16'd0 : r_line;
    assign w_col_use  = w_src_sof ? 16'd0 : r_col;
    assign w_adr      = 23'(w_line_use) * 23'(LINE_STRIDE) + 23'(w_col_use);
    assign w_accept   = pix_valid & r_pix_ready & ~w_test;

    // Write-cycle sequencing and next values of the registered bus outputs
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_line_nxt  = r_line;
        w_col_nxt   = r_col;
        w_adr_nxt   = r_mem_adr;
        w_data_nxt  = r_mem_data;
        w_oe_nxt    = r_mem_data_oe;
        w_wr_nxt    = r_mem_wr;
        w_ce_nxt    = r_ram_ce;
        w_be_nxt    = r_ram_be;
        w_req_nxt   = r_bus_req;
        w_done_nxt  = 1'b0;
        w_launch    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_nxt = w_src_full;
                if (w_src_full && bus_gnt) begin
                    w_launch    = 1'b1;
                    w_line_nxt  = w_line_use;
                    w_col_nxt   = w_col_use;
                    w_adr_nxt   = w_adr;
                    w_data_nxt  = w_src_word;
                    w_ce_nxt    = 1'b0;
                    w_be_nxt    = 1'b0;
                    w_oe_nxt    = 1'b1;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = S_SETUP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETUP: begin
                w_wr_nxt    = 1'b0;
                w_wcnt_nxt  = 8'd0;
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (r_wcnt == 8'(WR_PULSE - 1)) begin
                    w_wr_nxt    = 1'b1;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_wr_nxt   = 1'b0;
                    w_wcnt_nxt = r_wcnt + 8'd1;
                end
            end
            S_HOLD: begin
                // Counters move to the next word position; the frame wraps after the last word
                if (r_col == 16'(WORDS_PER_LINE - 1)) begin
                    w_col_nxt = 16'd0;
                    if (r_line == 16'(LINES - 1)) begin
                        w_line_nxt = 16'd0;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_line_nxt = r_line + 16'd1;
                    end
                end else begin
                    w_col_nxt = r_col + 16'd1;
                end
                w_ce_nxt    = 1'b1;
                w_oe_nxt    = 1'b0;
                w_be_nxt    = 1'b1;
                w_req_nxt   = 1'b0;
                w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pixel packer: low-byte slot feeding a one-entry pending word
    always_comb begin
        w_lo_nxt        = r_lo;
        w_lo_full_nxt   = r_lo_full;
        w_lo_sof_nxt    = r_lo_sof;
        w_pend_nxt      = r_pend;
        w_pend_sof_nxt  = r_pend_sof;
        w_pend_full_nxt = r_pend_full & ~(w_launch & ~w_test);
        if (w_accept) begin
            if (pix_sof || !r_lo_full) begin
                w_lo_nxt      = pix_data;
                w_lo_full_nxt = 1'b1;
                w_lo_sof_nxt  = pix_sof;
            end else begin
                w_pend_nxt      = {pix_data, r_lo};
                w_pend_full_nxt = 1'b1;
                w_pend_sof_nxt  = r_lo_sof;
                w_lo_full_nxt   = 1'b0;
                w_lo_sof_nxt    = 1'b0;
            end
        end else begin
            w_lo_nxt = r_lo;
        end
        w_ready_nxt = ~w_test & (~w_lo_full_nxt | ~w_pend_full_nxt);
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath, packer and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wcnt        <= 8'd0;
            r_line        <= 16'd0;
            r_col         <= 16'd0;
            r_lo          <= 8'd0;
            r_lo_full     <= 1'b0;
            r_lo_sof      <= 1'b0;
            r_pend        <= 16'd0;
            r_pend_full   <= 1'b0;
            r_pend_sof    <= 1'b0;
            r_mem_adr     <= 23'd0;
            r_mem_data    <= 16'd0;
            r_mem_data_oe <= 1'b0;
            r_mem_oe      <= 1'b1;
            r_mem_wr      <= 1'b1;
            r_ram_ce      <= 1'b1;
            r_ram_be      <= 1'b1;
            r_bus_req     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_pix_ready   <= 1'b1;
        end else begin
            r_wcnt        <= w_wcnt_nxt;
            r_line        <= w_line_nxt;
            r_col         <= w_col_nxt;
            r_lo          <= w_lo_nxt;
            r_lo_full     <= w_lo_full_nxt;
            r_lo_sof      <= w_lo_sof_nxt;
            r_pend        <= w_pend_nxt;
            r_pend_full   <= w_pend_full_nxt;
            r_pend_sof    <= w_pend_sof_nxt;
            r_mem_adr     <= w_adr_nxt;
            r_mem_data    <= w_data_nxt;
            r_mem_data_oe <= w_oe_nxt;
            r_mem_oe      <= 1'b1;
            r_mem_wr      <= w_wr_nxt;
            r_ram_ce      <= w_ce_nxt;
            r_ram_be      <= w_be_nxt;
            r_bus_req     <= w_req_nxt;
            r_frame_done  <= w_done_nxt;
            r_pix_ready   <= w_ready_nxt;
        end
    end

    assign pix_ready  = r_pix_ready;
    assign bus_req    = r_bus_req;
    assign MemAdr     = r_mem_adr;
    assign MemDataOut = r_mem_data;
    assign MemDataOE  = r_mem_data_oe;
    assign MemOE      = r_mem_oe;
    assign MemWR      = r_mem_wr;
    assign RamCE      = r_ram_ce;
    assign RamLB      = r_ram_be;
    assign RamUB      = r_ram_be;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_psram_frame_writer.sv
`timescale 1ns/1ps
// Scoreboard bench for psram_frame_writer: stimulus pushes expected {address, data} words,
// a negedge monitor pops them at each MemWR falling edge and checks pulse widths and frame_done.
module tb_psram_frame_writer;
    localparam int WPL = 320, NL = 3, STRIDE = 640, WRP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  pix_data = 8'h00;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic        pix_ready;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic [22:0] MemAdr;
    logic [15:0] MemDataOut;
    logic        MemDataOE, MemOE, MemWR, RamCE, RamLB, RamUB, frame_done;

    psram_frame_writer #(
        .WORDS_PER_LINE(WPL), .LINES(NL), .LINE_STRIDE(STRIDE), .WR_PULSE(WRP)
    ) dut (
        .clk(clk), .reset(reset),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_ready(pix_ready),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .MemAdr(MemAdr), .MemDataOut(MemDataOut), .MemDataOE(MemDataOE), .MemOE(MemOE),
        .MemWR(MemWR), .RamCE(RamCE), .RamLB(RamLB), .RamUB(RamUB), .frame_done(frame_done)
    );

    initial forever #10 clk = ~clk;

    int ncmp = 0, nfail = 0, fd_count = 0;
    int exp_line = 0, exp_col = 0;
    logic [38:0] exp_q[$];
    logic [22:0] last_adr = 23'd0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] d, input bit sof);
        if (sof) begin
            exp_line = 0;
            exp_col  = 0;
        end
        exp_q.push_back({23'(exp_line * STRIDE + exp_col), d});
        exp_col++;
        if (exp_col == WPL) begin
            exp_col = 0;
            exp_line++;
            if (exp_line == NL) exp_line = 0;
        end
    endtask

    task automatic send(input logic [7:0] d, input bit sof);
        int g = 0;
        pix_data  = d;
        pix_sof   = sof;
        pix_valid = 1'b1;
        while (!pix_ready && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) begin
            ncmp++;
            nfail++;
            $display("FAIL send_timeout: pixel %h not accepted", d);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic stream(input int n, input int seed);
        logic [7:0] p, lo;
        lo = 8'h00;
        for (int i = 0; i < n; i++) begin
            p = 8'(i * 7 + seed);
            send(p, i == 0);
            if (i % 2 == 1) push_word({p, lo}, i == 1);
            else lo = p;
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || !RamCE || bus_req) && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20000) begin
            ncmp++;
            nfail++;
            $display("FAIL drain_timeout: %0d words still expected", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops one expected word per write cycle and checks strobe widths
    initial begin
        logic prev_wr, prev_ce;
        int wr_len, ce_len;
        logic [38:0] e;
        prev_wr = 1'b1; prev_ce = 1'b1; wr_len = 0; ce_len = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_wr = 1'b1; prev_ce = 1'b1; wr_len = 0; ce_len = 0;
            end else begin
                if (!MemWR) begin
                    if (prev_wr) begin
                        if (exp_q.size() == 0) begin
                            ncmp++;
                            nfail++;
                            $display("FAIL unexpected_write: adr=%0d data=%h", MemAdr, MemDataOut);
                        end else begin
                            e = exp_q.pop_front();
                            check("write_adr", {9'd0, MemAdr}, {9'd0, e[38:16]});
                            check("write_data", {16'd0, MemDataOut}, {16'd0, e[15:0]});
                            check("write_ctl", {RamCE, RamLB, RamUB, MemDataOE, MemOE}, 32'b00011);
                        end
                        last_adr = MemAdr;
                    end
                    wr_len++;
                end else if (!prev_wr) begin
                    check("memwr_low_cycles", wr_len, WRP);
                    wr_len = 0;
                end
                if (!RamCE) ce_len++;
                else if (!prev_ce) begin
                    check("ramce_low_cycles", ce_len, WRP + 2);
                    ce_len = 0;
                end
                if (frame_done) begin
                    fd_count++;
                    check("frame_done_adr", {9'd0, last_adr}, (NL - 1) * STRIDE + WPL - 1);
                end
                prev_wr = MemWR;
                prev_ce = RamCE;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g;
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ctl", {MemWR, RamCE, MemOE, RamLB, RamUB, MemDataOE, bus_req, frame_done}, 32'b11111000);
        check("rst_adr", {9'd0, MemAdr}, 32'd0);
        check("rst_data", {16'd0, MemDataOut}, 32'd0);
        check("rst_ready", pix_ready, 1);
        reset = 1'b1;
        bus_gnt = 1'b1;
        repeat (2) @(negedge clk);

        // First word: launch one cycle after the pair completes
        send(8'h11, 1'b1);
        send(8'h22, 1'b0);
        push_word(16'h2211, 1'b1);
        @(negedge clk);
        check("t1_launch_ce", RamCE, 0);
        check("t1_launch_adr", {9'd0, MemAdr}, 32'd0);
        check("t1_launch_data", {16'd0, MemDataOut}, 32'h2211);
        check("t1_memoe", MemOE, 1);
        drain();

        // One line plus one word: 0..319 then 640
        stream(642, 3);
        drain();

        // Full frame (3 lines) plus one word: frame_done after 1599, then address 0
        stream(NL * WPL * 2 + 2, 5);
        drain();

        // Grant withheld with a pending word
        bus_gnt = 1'b0;
        send(8'h31, 1'b0);
        send(8'h32, 1'b0);
        push_word(16'h3231, 1'b0);
        repeat (3) @(negedge clk);
        check("t4_req_high", bus_req, 1);
        check("t4_no_activity", {RamCE, MemWR}, 32'b11);
        send(8'h33, 1'b0);
        pix_data = 8'h34;
        pix_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_ready_low", pix_ready, 0);
        check("t4_still_idle", RamCE, 1);
        bus_gnt = 1'b1;
        @(negedge clk);
        check("t4_launch", RamCE, 0);
        g = 0;
        while (!pix_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        pix_valid = 1'b0;
        push_word(16'h3433, 1'b0);
        drain();

        // sof mid-line: odd pixel 0x43 dropped, 0xBBAA goes to address 0
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        push_word(16'h4241, 1'b0);
        send(8'h43, 1'b0);
        send(8'hAA, 1'b1);
        send(8'hBB, 1'b0);
        push_word(16'hBBAA, 1'b1);
        drain();

        // Reset during WRITE
        send(8'h01, 1'b1);
        send(8'h02, 1'b0);
        push_word(16'h0201, 1'b1);
        g = 0;
        while (MemWR && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        check("t6_wr_low_before", MemWR, 0);
        #3 reset = 1'b0;
        #1;
        check("t6_async_ctl", {MemWR, RamCE, MemOE, MemDataOE}, 32'b1110);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_line = 0;
        exp_col = 0;
        repeat (2) @(negedge clk);
        check("t6_req_after", bus_req, 0);
        check("t6_ready_after", pix_ready, 1);
        check("t6_ce_after", RamCE, 1);

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("frame_done_count", fd_count, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
